// File: rtl/sht40_meas_sequencer_pkg.sv
// Shared definitions for the SHT40 measurement sequencer: FSM state encoding,
// CRC-8 parameters, SHT40 command set and receive-frame byte layout.
package sht40_meas_sequencer_pkg;

  // Sequencer states; encoding is visible on Seq_State_Out.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WR_REQ      = 3'd1,
    ST_WR_WAIT     = 3'd2,
    ST_MEAS_WAIT   = 3'd3,
    ST_RD_REQ      = 3'd4,
    ST_RD_DATA     = 3'd5,
    ST_PERIOD_WAIT = 3'd6,
    ST_FAULT       = 3'd7
  } seq_state_e;

  // Sensirion CRC-8: poly x^8+x^5+x^4+1, init 0xFF, no reflection, no final xor.
  localparam logic [7:0] CRC8_POLY = 8'h31;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  // SHT40 bus address and measurement commands.
  localparam logic [6:0] SHT40_I2C_ADDR       = 7'h44;
  localparam logic [7:0] SHT40_CMD_MEAS_HIGH  = 8'hFD;
  localparam logic [7:0] SHT40_CMD_MEAS_MED   = 8'hF6;
  localparam logic [7:0] SHT40_CMD_MEAS_LOW   = 8'hE0;
  localparam logic [7:0] SHT40_CMD_SOFT_RESET = 8'h94;

  // Measurement read frame layout.
  localparam int unsigned RX_FRAME_BYTES = 6;
  localparam int unsigned BYTE_CNT_W     = 3;
  localparam int unsigned IDX_T_MSB      = 0;
  localparam int unsigned IDX_T_LSB      = 1;
  localparam int unsigned IDX_T_CRC      = 2;
  localparam int unsigned IDX_RH_MSB     = 3;
  localparam int unsigned IDX_RH_LSB     = 4;
  localparam int unsigned IDX_RH_CRC     = 5;

endpackage

// File: rtl/sht_crc8.sv
// Combinational Sensirion CRC-8 over one 16-bit word sent MSB byte first.
// Ports: msb_i/lsb_i - data bytes in transmission order; crc_o - CRC result.
module sht_crc8
  import sht40_meas_sequencer_pkg::*;
(
  input  logic [7:0] msb_i,
  input  logic [7:0] lsb_i,
  output logic [7:0] crc_o
);

  logic [15:0] word;
  logic [7:0]  crc;

  // Bit-serial MSB-first CRC unrolled over all 16 data bits.
  always_comb begin
    word = {msb_i, lsb_i};
    crc  = CRC8_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ word[i]) begin
        crc = (crc << 1) ^ CRC8_POLY;
      end else begin
        crc = crc << 1;
      end
    end
    crc_o = crc;
  end

endmodule

// File: rtl/sht40_meas_sequencer.sv
// SHT40 measurement sequencer: drives an i2c_master through write-command,
// conversion wait and 6-byte read, checks both CRCs, publishes raw words,
// retries failed measurements and latches a fault after MAX_RETRY failures.
// Ports:
//   clk, Reset                         - clock, synchronous active-high reset
//   Enable, Single_Shot                - periodic mode level / one-shot pulse
//   Cmd_Valid, Cmd_Ready, Cmd_Read     - transfer request handshake to master
//   Peripheral_Address, Command_Data_Frames - constant address and command
//   Rx_Data, Rx_Valid                  - received byte stream
//   Xfer_Done, Xfer_Nack               - transfer completion and NACK status
//   Temperature_Output, Humidity_Output - last CRC-good raw words
//   Sample_Valid                       - one-cycle pulse per new sample
//   CRC_Error, Sensor_Fault, Busy      - status flags
//   Seq_State_Out                      - current FSM state
module sht40_meas_sequencer
  import sht40_meas_sequencer_pkg::*;
#(
  parameter logic [6:0]  SENSOR_ADDR      = SHT40_I2C_ADDR,
  parameter logic [7:0]  MEAS_CMD         = SHT40_CMD_MEAS_HIGH,
  parameter int unsigned MEAS_WAIT_CYCLES = 1000,
  parameter int unsigned PERIOD_CYCLES    = 5000,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        Single_Shot,
  output logic        Cmd_Valid,
  input  logic        Cmd_Ready,
  output logic        Cmd_Read,
  output logic [6:0]  Peripheral_Address,
  output logic [7:0]  Command_Data_Frames,
  input  logic [7:0]  Rx_Data,
  input  logic        Rx_Valid,
  input  logic        Xfer_Done,
  input  logic        Xfer_Nack,
  output logic [15:0] Temperature_Output,
  output logic [15:0] Humidity_Output,
  output logic        Sample_Valid,
  output logic        CRC_Error,
  output logic        Sensor_Fault,
  output logic        Busy,
  output logic [2:0]  Seq_State_Out
);

  localparam int unsigned MAX_WAIT = (MEAS_WAIT_CYCLES > PERIOD_CYCLES) ?
                                     MEAS_WAIT_CYCLES : PERIOD_CYCLES;
  localparam int unsigned CNT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 1);

  seq_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]           rx_buf_q [RX_FRAME_BYTES];
  logic [7:0]           rx_buf_d [RX_FRAME_BYTES];
  logic                 periodic_q, periodic_d;
  logic [15:0]          temp_q, temp_d;
  logic [15:0]          hum_q, hum_d;
  logic                 sample_valid_q, sample_valid_d;
  logic                 crc_err_q, crc_err_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 cmd_read_q, cmd_read_d;
  logic                 retry_fail;
  logic                 frame_full;
  logic [7:0]           crc_t, crc_rh;
  logic                 crc_ok;

  // Byte capture; a byte arriving with Xfer_Done is merged before evaluation.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    rx_buf_d   = rx_buf_q;
    if (state_q == ST_RD_REQ) begin
      byte_cnt_d = '0;
    end else if ((state_q == ST_RD_DATA) && Rx_Valid &&
                 (byte_cnt_q < BYTE_CNT_W'(RX_FRAME_BYTES))) begin
      rx_buf_d[byte_cnt_q] = Rx_Data;
      byte_cnt_d           = byte_cnt_q + BYTE_CNT_W'(1);
    end
  end

  assign frame_full = (byte_cnt_d == BYTE_CNT_W'(RX_FRAME_BYTES));

  sht_crc8 u_crc_t (
    .msb_i (rx_buf_d[IDX_T_MSB]),
    .lsb_i (rx_buf_d[IDX_T_LSB]),
    .crc_o (crc_t)
  );

  sht_crc8 u_crc_rh (
    .msb_i (rx_buf_d[IDX_RH_MSB]),
    .lsb_i (rx_buf_d[IDX_RH_LSB]),
    .crc_o (crc_rh)
  );

  assign crc_ok    = (crc_t == rx_buf_d[IDX_T_CRC]) && (crc_rh == rx_buf_d[IDX_RH_CRC]);
  assign retry_inc = retry_q + RETRY_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    retry_d        = retry_q;
    periodic_d     = periodic_q;
    temp_d         = temp_q;
    hum_d          = hum_q;
    sample_valid_d = 1'b0;
    crc_err_d      = crc_err_q;
    retry_fail     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Enable || Single_Shot) begin
          state_d    = ST_WR_REQ;
          periodic_d = Enable;
          retry_d    = '0;
        end
      end
      ST_WR_REQ: begin
        if (Cmd_Ready) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (Xfer_Done) begin
          if (Xfer_Nack) begin
            retry_fail = 1'b1;
          end else begin
            state_d = ST_MEAS_WAIT;
            cnt_d   = CNT_W'(MEAS_WAIT_CYCLES - 1);
          end
        end
      end
      ST_MEAS_WAIT: begin
        if (cnt_q == '0) state_d = ST_RD_REQ;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RD_REQ: begin
        if (Cmd_Ready) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (Xfer_Done) begin
          if (Xfer_Nack || !frame_full) begin
            retry_fail = 1'b1;
          end else if (!crc_ok) begin
            crc_err_d  = 1'b1;
            retry_fail = 1'b1;
          end else begin
            temp_d         = {rx_buf_d[IDX_T_MSB], rx_buf_d[IDX_T_LSB]};
            hum_d          = {rx_buf_d[IDX_RH_MSB], rx_buf_d[IDX_RH_LSB]};
            sample_valid_d = 1'b1;
            crc_err_d      = 1'b0;
            retry_d        = '0;
            cnt_d          = CNT_W'(PERIOD_CYCLES - 1);
            // A dropped Enable ends periodic mode after this sample.
            state_d        = (periodic_q && Enable) ? ST_PERIOD_WAIT : ST_IDLE;
          end
        end
      end
      ST_PERIOD_WAIT: begin
        if (cnt_q == '0) state_d = Enable ? ST_WR_REQ : ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Failed attempt: restart from the write, or give up at the retry limit.
    if (retry_fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc >= RETRY_W'(MAX_RETRY)) ? ST_FAULT : ST_WR_REQ;
    end

    // Flags registered from the next state so they line up with state_q.
    cmd_valid_d = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
    cmd_read_d  = (state_d == ST_RD_REQ);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    fault_d     = (state_d == ST_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      retry_q        <= '0;
      byte_cnt_q     <= '0;
      rx_buf_q       <= '{default: '0};
      periodic_q     <= 1'b0;
      temp_q         <= 16'h0000;
      hum_q          <= 16'h0000;
      sample_valid_q <= 1'b0;
      crc_err_q      <= 1'b0;
      fault_q        <= 1'b0;
      busy_q         <= 1'b0;
      cmd_valid_q    <= 1'b0;
      cmd_read_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      byte_cnt_q     <= byte_cnt_d;
      rx_buf_q       <= rx_buf_d;
      periodic_q     <= periodic_d;
      temp_q         <= temp_d;
      hum_q          <= hum_d;
      sample_valid_q <= sample_valid_d;
      crc_err_q      <= crc_err_d;
      fault_q        <= fault_d;
      busy_q         <= busy_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_read_q     <= cmd_read_d;
    end
  end

  assign Cmd_Valid           = cmd_valid_q;
  assign Cmd_Read            = cmd_read_q;
  assign Peripheral_Address  = SENSOR_ADDR;
  assign Command_Data_Frames = MEAS_CMD;
  assign Temperature_Output  = temp_q;
  assign Humidity_Output     = hum_q;
  assign Sample_Valid        = sample_valid_q;
  assign CRC_Error           = crc_err_q;
  assign Sensor_Fault        = fault_q;
  assign Busy                = busy_q;
  assign Seq_State_Out       = state_q;

endmodule

// File: tb/tb_sht40_meas_sequencer.sv
// Directed testbench for sht40_meas_sequencer with short wait parameters.
module tb_sht40_meas_sequencer;

  localparam int unsigned MEAS_W = 4;
  localparam int unsigned PER_W  = 6;

  logic        clk = 1'b0;
  logic        Reset, Enable, Single_Shot;
  logic        Cmd_Valid, Cmd_Ready, Cmd_Read;
  logic [6:0]  Peripheral_Address;
  logic [7:0]  Command_Data_Frames;
  logic [7:0]  Rx_Data;
  logic        Rx_Valid, Xfer_Done, Xfer_Nack;
  logic [15:0] Temperature_Output, Humidity_Output;
  logic        Sample_Valid, CRC_Error, Sensor_Fault, Busy;
  logic [2:0]  Seq_State_Out;

  int tests = 0;
  int fails = 0;
  int n;
  logic [7:0] pay [8];

  always #5 clk = ~clk;

  sht40_meas_sequencer #(
    .SENSOR_ADDR      (7'h44),
    .MEAS_CMD         (8'hFD),
    .MEAS_WAIT_CYCLES (MEAS_W),
    .PERIOD_CYCLES    (PER_W),
    .MAX_RETRY        (3)
  ) dut (
    .clk                 (clk),
    .Reset               (Reset),
    .Enable              (Enable),
    .Single_Shot         (Single_Shot),
    .Cmd_Valid           (Cmd_Valid),
    .Cmd_Ready           (Cmd_Ready),
    .Cmd_Read            (Cmd_Read),
    .Peripheral_Address  (Peripheral_Address),
    .Command_Data_Frames (Command_Data_Frames),
    .Rx_Data             (Rx_Data),
    .Rx_Valid            (Rx_Valid),
    .Xfer_Done           (Xfer_Done),
    .Xfer_Nack           (Xfer_Nack),
    .Temperature_Output  (Temperature_Output),
    .Humidity_Output     (Humidity_Output),
    .Sample_Valid        (Sample_Valid),
    .CRC_Error           (CRC_Error),
    .Sensor_Fault        (Sensor_Fault),
    .Busy                (Busy),
    .Seq_State_Out       (Seq_State_Out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check its direction, then accept it.
  task automatic wait_req(input string tag, input logic rd, output int cycles);
    cycles = 0;
    while (Cmd_Valid !== 1'b1 && cycles < 200) begin
      step();
      cycles++;
    end
    check({tag, "_valid"}, 32'(Cmd_Valid), 32'd1);
    check({tag, "_read"}, 32'(Cmd_Read), 32'(rd));
    Cmd_Ready = 1'b1;
    step();
    Cmd_Ready = 1'b0;
  endtask

  task automatic write_xfer(input logic nack);
    step();
    Xfer_Done = 1'b1;
    Xfer_Nack = nack;
    step();
    Xfer_Done = 1'b0;
    Xfer_Nack = 1'b0;
  endtask

  // Deliver pay[0..cnt-1]; optionally raise Xfer_Done with the last byte.
  task automatic read_xfer(input int cnt, input logic done_with_last);
    for (int i = 0; i < cnt; i++) begin
      Rx_Data  = pay[i];
      Rx_Valid = 1'b1;
      if (done_with_last && i == cnt - 1) Xfer_Done = 1'b1;
      step();
    end
    Rx_Valid = 1'b0;
    if (!done_with_last) begin
      Xfer_Done = 1'b1;
      step();
    end
    Xfer_Done = 1'b0;
  endtask

  task automatic pulse_single();
    Single_Shot = 1'b1;
    step();
    Single_Shot = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Enable = 1'b0; Single_Shot = 1'b0; Cmd_Ready = 1'b0;
    Rx_Data = 8'h00; Rx_Valid = 1'b0; Xfer_Done = 1'b0; Xfer_Nack = 1'b0;
    step(); step();
    Reset = 1'b0;
    step();

    // Reset state
    check("rst_state", 32'(Seq_State_Out), 32'd0);
    check("rst_cmd_valid", 32'(Cmd_Valid), 32'd0);
    check("rst_cmd_read", 32'(Cmd_Read), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_temp", 32'(Temperature_Output), 32'h0000);
    check("rst_hum", 32'(Humidity_Output), 32'h0000);
    check("rst_flags", 32'({Sample_Valid, CRC_Error, Sensor_Fault}), 32'd0);
    check("addr", 32'(Peripheral_Address), 32'h44);
    check("cmd", 32'(Command_Data_Frames), 32'hFD);

    // Periodic measurement, good frame 66 66 93 80 00 A2
    Enable = 1'b1;
    wait_req("a_wr", 1'b0, n);
    check("a_busy", 32'(Busy), 32'd1);
    check("a_wr_wait", 32'(Seq_State_Out), 32'd2);
    write_xfer(1'b0);
    check("a_meas_state", 32'(Seq_State_Out), 32'd3);
    wait_req("a_rd", 1'b1, n);
    check("a_meas_cycles", 32'(n), 32'(MEAS_W));
    check("a_rd_data", 32'(Seq_State_Out), 32'd5);
    pay = '{8'h66, 8'h66, 8'h93, 8'h80, 8'h00, 8'hA2, 8'h00, 8'h00};
    read_xfer(6, 1'b0);
    check("a_sv", 32'(Sample_Valid), 32'd1);
    check("a_temp", 32'(Temperature_Output), 32'h6666);
    check("a_hum", 32'(Humidity_Output), 32'h8000);
    check("a_period", 32'(Seq_State_Out), 32'd6);
    check("a_crc_err", 32'(CRC_Error), 32'd0);
    step();
    check("a_sv_once", 32'(Sample_Valid), 32'd0);

    // Second periodic round; Enable drops mid-measurement, last byte with Done
    wait_req("b_wr", 1'b0, n);
    check("b_period_cycles", 32'(n + 1), 32'(PER_W));
    write_xfer(1'b0);
    Enable = 1'b0;
    wait_req("b_rd", 1'b1, n);
    pay = '{8'hBE, 8'hEF, 8'h92, 8'h66, 8'h66, 8'h93, 8'h00, 8'h00};
    read_xfer(6, 1'b1);
    check("b_sv", 32'(Sample_Valid), 32'd1);
    check("b_temp", 32'(Temperature_Output), 32'hBEEF);
    check("b_hum", 32'(Humidity_Output), 32'h6666);
    check("b_idle", 32'(Seq_State_Out), 32'd0);
    check("b_busy", 32'(Busy), 32'd0);

    // Single shot: two write NACKs then ACK; Single_Shot in MEAS_WAIT ignored
    pulse_single();
    for (int i = 0; i < 3; i++) begin
      wait_req("c_wr", 1'b0, n);
      write_xfer(i < 2);
      if (i < 2) check("c_retry_state", 32'(Seq_State_Out), 32'd1);
    end
    check("c_meas_state", 32'(Seq_State_Out), 32'd3);
    check("c_no_fault", 32'(Sensor_Fault), 32'd0);
    pulse_single();
    check("c_ss_ignored", 32'(Seq_State_Out), 32'd3);
    wait_req("c_rd", 1'b1, n);
    pay = '{8'h80, 8'h00, 8'hA2, 8'h66, 8'h66, 8'h93, 8'h55, 8'h00};
    read_xfer(7, 1'b0);
    check("c_sv", 32'(Sample_Valid), 32'd1);
    check("c_temp", 32'(Temperature_Output), 32'h8000);
    check("c_hum", 32'(Humidity_Output), 32'h6666);
    check("c_idle", 32'(Seq_State_Out), 32'd0);
    check("c_fault", 32'(Sensor_Fault), 32'd0);
    step(); step(); step();
    check("c_idle_stays", 32'(Seq_State_Out), 32'd0);
    check("c_no_req", 32'(Cmd_Valid), 32'd0);

    // Short read (4 bytes) -> retry with outputs held, then a good read
    pulse_single();
    wait_req("d_wr", 1'b0, n);
    write_xfer(1'b0);
    wait_req("d_rd", 1'b1, n);
    pay = '{8'h66, 8'h66, 8'h93, 8'h80, 8'h00, 8'hA2, 8'h00, 8'h00};
    read_xfer(4, 1'b0);
    check("d_retry_state", 32'(Seq_State_Out), 32'd1);
    check("d_temp_held", 32'(Temperature_Output), 32'h8000);
    check("d_hum_held", 32'(Humidity_Output), 32'h6666);
    check("d_sv", 32'(Sample_Valid), 32'd0);
    check("d_crc_err", 32'(CRC_Error), 32'd0);
    wait_req("d_wr2", 1'b0, n);
    write_xfer(1'b0);
    wait_req("d_rd2", 1'b1, n);
    read_xfer(6, 1'b0);
    check("d_temp", 32'(Temperature_Output), 32'h6666);
    check("d_hum", 32'(Humidity_Output), 32'h8000);
    check("d_sv2", 32'(Sample_Valid), 32'd1);

    // Reset during RD_DATA, then a stale Xfer_Done in IDLE
    pulse_single();
    wait_req("e_wr", 1'b0, n);
    write_xfer(1'b0);
    wait_req("e_rd", 1'b1, n);
    Rx_Data = 8'h12; Rx_Valid = 1'b1; step();
    Rx_Data = 8'h34; step();
    Rx_Valid = 1'b0;
    check("e_rd_state", 32'(Seq_State_Out), 32'd5);
    Reset = 1'b1;
    step();
    check("e_rst_state", 32'(Seq_State_Out), 32'd0);
    check("e_rst_temp", 32'(Temperature_Output), 32'h0000);
    check("e_rst_hum", 32'(Humidity_Output), 32'h0000);
    check("e_rst_cmd", 32'({Cmd_Valid, Cmd_Read}), 32'd0);
    check("e_rst_flags", 32'({Sample_Valid, CRC_Error, Sensor_Fault, Busy}), 32'd0);
    Reset = 1'b0;
    Xfer_Done = 1'b1;
    step();
    Xfer_Done = 1'b0;
    step();
    check("e_stale_done", 32'(Seq_State_Out), 32'd0);
    check("e_stale_req", 32'(Cmd_Valid), 32'd0);

    // Bad T_crc on every read -> CRC_Error and FAULT after 3 attempts
    pulse_single();
    pay = '{8'h66, 8'h66, 8'h00, 8'h80, 8'h00, 8'hA2, 8'h00, 8'h00};
    for (int i = 0; i < 3; i++) begin
      wait_req("f_wr", 1'b0, n);
      write_xfer(1'b0);
      wait_req("f_rd", 1'b1, n);
      read_xfer(6, 1'b0);
      if (i == 0) begin
        check("f_crc_err", 32'(CRC_Error), 32'd1);
        check("f_retry_state", 32'(Seq_State_Out), 32'd1);
        check("f_temp_held", 32'(Temperature_Output), 32'h0000);
        check("f_sv", 32'(Sample_Valid), 32'd0);
      end
    end
    check("f_fault_state", 32'(Seq_State_Out), 32'd7);
    check("f_fault_flag", 32'(Sensor_Fault), 32'd1);
    check("f_busy", 32'(Busy), 32'd0);
    check("f_crc_sticky", 32'(CRC_Error), 32'd1);
    Enable = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("f_fault_stays", 32'(Seq_State_Out), 32'd7);
    check("f_no_req", 32'(Cmd_Valid), 32'd0);
    Enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
